rf_debug_access: RTL and testbench

- Debug-side initiator for the processor's 32x32 register file. Accepts single-word read, single-word write and full-dump commands over a valid/ready command channel.
- Drives the register file's read-address, write-enable, write-address and write-data pins, and returns results over a valid/ready response stream.
- Sits beside the core datapath. Its write port is muxed onto the register file write pins only while the core is halted.

---
 rtl/rf_debug_access_if.sv | 37 +++
 rtl/rf_debug_access.sv | 164 ++++++++++++++++
 tb/tb_rf_debug_access.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_debug_access_if.sv
// Command, response and register-file pin bundle for the debug register-file initiator.
// The design side uses the slave modport; the debug host / register file side uses master.
interface rf_debug_access_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic [ADDR_W-1:0] rf_ad;
  logic [DATA_W-1:0] rf_rd;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_ad3;
  logic [DATA_W-1:0] rf_wd3;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_last;
  logic              rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rf_rd, rsp_ready,
    output cmd_ready, rf_ad, rf_we, rf_ad3, rf_wd3,
           rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rf_rd, rsp_ready,
    input  cmd_ready, rf_ad, rf_we, rf_ad3, rf_wd3,
           rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_err
  );
endinterface

// File: rtl/rf_debug_access.sv
// Debug-side initiator for the register file: single read, single write (only while the
// core is halted, x0 protected) and full dump, with results on a valid/ready stream.
module rf_debug_access #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             core_halted_i,
  output logic             busy_o,
  rf_debug_access_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WRITE   = 3'd2,
    S_DUMP_RD = 3'd3,
    S_RSP     = 3'd4
  } state_e;

  localparam logic [1:0]      OP_READ  = 2'b00;
  localparam logic [1:0]      OP_WRITE = 2'b01;
  localparam logic [1:0]      OP_DUMP  = 2'b10;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   index_q, index_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] rf_ad_q, rf_ad_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic              rsp_last_q, rsp_last_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rf_we_s;

  // State and datapath registers; reset drops any in-flight command or pending response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      index_q    <= {(ADDR_W+1){1'b0}};
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      rf_ad_q    <= {ADDR_W{1'b0}};
      rsp_data_q <= {DATA_W{1'b0}};
      rsp_addr_q <= {ADDR_W{1'b0}};
      rsp_last_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rf_ad_q    <= rf_ad_d;
      rsp_data_q <= rsp_data_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_last_q <= rsp_last_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state and register-file strobe decode.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rf_ad_d    = rf_ad_q;
    rsp_data_d = rsp_data_q;
    rsp_addr_d = rsp_addr_q;
    rsp_last_d = rsp_last_q;
    rsp_err_d  = rsp_err_q;
    rf_we_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d     = bus.cmd_addr;
          wdata_d    = bus.cmd_wdata;
          rsp_data_d = {DATA_W{1'b0}};
          rsp_addr_d = bus.cmd_addr;
          rsp_last_d = 1'b1;
          rsp_err_d  = 1'b0;
          case (bus.cmd_op)
            OP_READ: begin
              rf_ad_d = bus.cmd_addr;
              state_d = S_READ;
            end
            OP_WRITE: begin
              state_d = S_WRITE;
            end
            OP_DUMP: begin
              // A dump is only allowed to start while the core is halted.
              if (core_halted_i) begin
                index_d = {(ADDR_W+1){1'b0}};
                rf_ad_d = {ADDR_W{1'b0}};
                state_d = S_DUMP_RD;
              end else begin
                rsp_addr_d = {ADDR_W{1'b0}};
                rsp_err_d  = 1'b1;
                state_d    = S_RSP;
              end
            end
            default: begin
              rsp_err_d = 1'b1;
              state_d   = S_RSP;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        rsp_data_d = bus.rf_rd;
        state_d    = S_RSP;
      end
      S_WRITE: begin
        if (core_halted_i && (addr_q != {ADDR_W{1'b0}})) begin
          rf_we_s = 1'b1;
        end else begin
          rf_we_s = 1'b0;
        end
        rsp_err_d = ~core_halted_i;
        state_d   = S_RSP;
      end
      S_DUMP_RD: begin
        rsp_data_d = bus.rf_rd;
        rsp_addr_d = index_q[ADDR_W-1:0];
        rsp_last_d = (index_q == LAST_IDX);
        state_d    = S_RSP;
      end
      S_RSP: begin
        // Only dump words can be non-last, so a non-last handshake always continues the scan.
        if (bus.rsp_ready) begin
          if (!rsp_last_q) begin
            index_d = index_q + IDX_ONE;
            rf_ad_d = index_d[ADDR_W-1:0];
            state_d = S_DUMP_RD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_RSP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign bus.rf_ad     = rf_ad_q;
  assign bus.rf_we     = rf_we_s;
  assign bus.rf_ad3    = addr_q;
  assign bus.rf_wd3    = wdata_q;
  assign bus.rsp_valid = (state_q == S_RSP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_rf_debug_access.sv
// Randomized self-checking bench for rf_debug_access with a behavioural register-file
// and response model.
module tb_rf_debug_access;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  logic clk = 1'b0;
  logic rst;
  logic core_halted;
  logic busy;
  logic rf_init;

  int tests = 0;
  int fails = 0;

  rf_debug_access_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rf_debug_access #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .core_halted_i(core_halted),
    .busy_o       (busy),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        last;
    logic        err;
    logic        addr_dc;
  } rsp_t;

  logic [31:0] rf_mem [NUM_REGS];
  logic [31:0] ref_rf [NUM_REGS];
  rsp_t        exp_q[$];

  function automatic logic [31:0] init_val(int i);
    if (i == 5) return 32'hDEADBEEF;
    return 32'(i * 16);
  endfunction

  // Register file: combinational read, synchronous write.
  assign bus.rf_rd = rf_mem[bus.rf_ad];
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < NUM_REGS; i++) rf_mem[i] <= init_val(i);
    end else if (bus.rf_we) begin
      rf_mem[bus.rf_ad3] <= bus.rf_wd3;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Issue one command and drain its responses, comparing against the model.
  task automatic do_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] wdata,
                        input bit halted, input int rdy_mode);
    rsp_t e;
    logic [38:0] prev, cur;
    bit stalled = 1'b0;
    int first_valid = -1;
    int cyc = 0;
    bit exp_we, direct_rsp, dump_run, rdy;

    core_halted = halted;
    exp_q.delete();
    case (op)
      2'b00: exp_q.push_back('{ref_rf[addr], addr, 1'b1, 1'b0, 1'b0});
      2'b01: begin
        if (halted && addr != 5'd0) ref_rf[addr] = wdata;
        exp_q.push_back('{32'h0, addr, 1'b1, !halted, 1'b0});
      end
      2'b10: begin
        if (halted) begin
          for (int i = 0; i < NUM_REGS; i++)
            exp_q.push_back('{ref_rf[i], 5'(i), (i == NUM_REGS - 1), 1'b0, 1'b0});
        end else begin
          exp_q.push_back('{32'h0, 5'd0, 1'b1, 1'b1, 1'b0});
        end
      end
      default: exp_q.push_back('{32'h0, 5'd0, 1'b1, 1'b1, 1'b1});
    endcase
    exp_we     = (op == 2'b01) && halted && (addr != 5'd0);
    direct_rsp = (op == 2'b11) || (op == 2'b10 && !halted);
    dump_run   = (op == 2'b10) && halted;

    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.rsp_ready = 1'b0;
    check_val("cmd_ready", bus.cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check_val("busy_after_accept", busy, 1);
    check_val("rf_we_write_cycle", bus.rf_we, exp_we);
    if (exp_we) begin
      check_val("rf_ad3", bus.rf_ad3, addr);
      check_val("rf_wd3", bus.rf_wd3, wdata);
    end

    while (exp_q.size() > 0 && cyc < 600) begin
      if (cyc > 0) check_val("rf_we_quiet", bus.rf_we, 0);
      if (dump_run) core_halted = 1'($urandom_range(0, 1));
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.rsp_ready = rdy;
      cur = {bus.rsp_data, bus.rsp_addr, bus.rsp_last, bus.rsp_err};
      if (stalled) begin
        check_val("rsp_held_valid", bus.rsp_valid, 1);
        check_val("rsp_held_stable", cur, prev);
      end
      if (bus.rsp_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          check_val("rsp_latency", 64'(cyc), direct_rsp ? 64'd0 : 64'd1);
        end
        if (rdy) begin
          e = exp_q.pop_front();
          check_val("rsp_data", bus.rsp_data, e.data);
          if (!e.addr_dc) check_val("rsp_addr", bus.rsp_addr, e.addr);
          check_val("rsp_last", bus.rsp_last, e.last);
          check_val("rsp_err", bus.rsp_err, e.err);
          if (dump_run && rdy_mode == 0 && exp_q.size() == 0)
            check_val("dump_cycles", 64'(cyc), 64'd63);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev    = cur;
        end
      end else begin
        stalled = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check_val("rsp_remaining", 64'(exp_q.size()), 0);
    bus.rsp_ready = 1'b0;
    check_val("idle_busy", busy, 0);
    check_val("idle_cmd_ready", bus.cmd_ready, 1);
    check_val("idle_rsp_valid", bus.rsp_valid, 0);
  endtask

  initial begin
    logic [1:0] op;
    int guard;
    bit found;

    rst = 1'b1;
    rf_init = 1'b1;
    core_halted = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_addr = 5'd0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) ref_rf[i] = init_val(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rf_init = 1'b0;

    check_val("rst_cmd_ready", bus.cmd_ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_rsp_valid", bus.rsp_valid, 0);
    check_val("rst_rsp_data", bus.rsp_data, 0);
    check_val("rst_rsp_addr", bus.rsp_addr, 0);
    check_val("rst_rsp_last", bus.rsp_last, 0);
    check_val("rst_rsp_err", bus.rsp_err, 0);
    check_val("rst_rf_we", bus.rf_we, 0);
    check_val("rst_rf_ad", bus.rf_ad, 0);
    check_val("rst_rf_ad3", bus.rf_ad3, 0);
    check_val("rst_rf_wd3", bus.rf_wd3, 0);

    do_cmd(2'b00, 5'd5, 32'h0, 1'b1, 0);
    do_cmd(2'b01, 5'd7, 32'h12345678, 1'b1, 0);
    do_cmd(2'b00, 5'd7, 32'h0, 1'b1, 0);
    do_cmd(2'b01, 5'd0, 32'hFFFFFFFF, 1'b1, 0);
    do_cmd(2'b00, 5'd0, 32'h0, 1'b0, 0);
    do_cmd(2'b01, 5'd3, 32'hCAFEF00D, 1'b0, 0);
    do_cmd(2'b00, 5'd3, 32'h0, 1'b0, 0);
    do_cmd(2'b11, 5'd9, 32'h0, 1'b1, 0);
    do_cmd(2'b10, 5'd0, 32'h0, 1'b0, 0);
    do_cmd(2'b10, 5'd0, 32'h0, 1'b1, 1);
    do_cmd(2'b10, 5'd0, 32'h0, 1'b1, 0);

    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'b10 && $urandom_range(0, 1) == 0) op = 2'b00;
      do_cmd(op, 5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 3) != 0),
             $urandom_range(0, 2));
    end

    // Reset while word 10 of a dump is being presented.
    core_halted = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'b10;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    found = 1'b0;
    guard = 0;
    while (!found && guard < 200) begin
      if (bus.rsp_valid && bus.rsp_addr == 5'd10) begin
        found = 1'b1;
        bus.rsp_ready = 1'b0;
      end else begin
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        guard++;
      end
    end
    check_val("dump_word10_seen", found, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_rsp_valid", bus.rsp_valid, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_cmd_ready", bus.cmd_ready, 1);
    check_val("midrst_rf_we", bus.rf_we, 0);
    check_val("midrst_rsp_data", bus.rsp_data, 0);
    do_cmd(2'b00, 5'd2, 32'h0, 1'b1, 0);

    // Reset coinciding with a write handshake: the write must be lost.
    @(negedge clk);
    core_halted = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'b01;
    bus.cmd_addr = 5'd9;
    bus.cmd_wdata = 32'hA5A5A5A5;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    check_val("rstcmd_busy", busy, 0);
    check_val("rstcmd_rf_we", bus.rf_we, 0);
    @(posedge clk);
    @(negedge clk);
    check_val("rstcmd_rf_we_next", bus.rf_we, 0);
    do_cmd(2'b00, 5'd9, 32'h0, 1'b1, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
